// File: rtl/mult_hilo_ctrl_if.sv
// EX-stage side of the multiply/HI-LO controller: request, HI/LO moves and status.
interface mult_hilo_ctrl_if;
    localparam int unsigned DATA_W = 32;

    logic              start;
    logic              is_signed;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              flush;
    logic              mthi;
    logic              mtlo;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, is_signed, op_a, op_b, flush, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, op_a, op_b, flush, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// Issue/write-back controller for a pipelined 32x32 unsigned multiplier.
// Owns HI/LO, counts multiplier latency and applies signed correction for MULT.
module mult_hilo_ctrl #(
    parameter int unsigned LATENCY = 6,
    parameter int unsigned CNT_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    mult_hilo_ctrl_if.slave     bus,
    output logic [31:0]         mul_a,
    output logic [31:0]         mul_b,
    input  logic [63:0]         mul_z
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sgn;
    logic [63:0]      corr_c;

    // Signed correction: subtract the extra 2^32 * other-operand terms of a negative operand.
    always_comb begin
        corr_c = mul_z;
        if (sgn) begin
            corr_c = mul_z
                   - (mul_a[31] ? {mul_b, 32'b0} : 64'b0)
                   - (mul_b[31] ? {mul_a, 32'b0} : 64'b0);
        end
    end

    // Controller FSM, operand latches and HI/LO registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sgn      <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            bus.hi   <= '0;
            bus.lo   <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        mul_a    <= bus.op_a;
                        mul_b    <= bus.op_b;
                        sgn      <= bus.is_signed;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= WAIT;
                    end else if (!bus.start) begin
                        // HI/LO moves only when no multiply is being issued this cycle
                        if (bus.mthi) bus.hi <= bus.wdata;
                        if (bus.mtlo) bus.lo <= bus.wdata;
                    end
                end
                WAIT: begin
                    if (bus.flush) begin
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        {bus.hi, bus.lo} <= corr_c;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
